param_sequence_detector: RTL and testbench

PARAM_SEQUENCE_DETECTOR -- requirements
Module: param_sequence_detector

---
 rtl/seqdet_pkg.sv | 22 ++
 rtl/seqdet_sat_counter.sv | 38 +++
 rtl/param_sequence_detector.sv | 94 +++++++++
 tb/tb_param_sequence_detector.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seqdet_pkg
//  Description : Shared types and limits for the serial sequence detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package seqdet_pkg;

    // Detection mode: overlapping keeps the history after a match so pattern
    // suffixes can count toward the next one, non-overlapping restarts the fill.
    typedef enum logic {
        MODE_NONOVERLAP = 1'b0,
        MODE_OVERLAP    = 1'b1
    } seqdet_mode_t;

    localparam int PAT_LEN_MIN = 2;
    localparam int PAT_LEN_MAX = 16;
    localparam int CNT_W_MIN   = 2;
    localparam int CNT_W_MAX   = 32;

endpackage : seqdet_pkg
`default_nettype wire

// File: rtl/seqdet_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : seqdet_sat_counter
//  Description : W-bit up counter that sticks at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module seqdet_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);

    logic [W-1:0] r_count;
    logic         w_full;

    assign w_full = &r_count;

    // Count up on inc, clear has priority, freeze once every bit is set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !w_full) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign sat   = w_full;

endmodule : seqdet_sat_counter
`default_nettype wire

// File: rtl/param_sequence_detector.sv
`default_nettype none
// ============================================================================
//  Module      : param_sequence_detector
//  Description : Runtime-configurable serial pattern detector with
//                overlapping / non-overlapping modes and a saturating
//                match counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_sequence_detector
    import seqdet_pkg::*;
#(
    parameter int                 PAT_LEN     = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [PAT_LEN-1:0] DEF_PATTERN = PAT_LEN'(4'b0110),
    parameter seqdet_mode_t       DEF_MODE    = MODE_OVERLAP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               data_in,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               cfg_mode,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    // Reject illegal configurations at elaboration.
    if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_pat_len
        $error("param_sequence_detector: PAT_LEN out of range");
    end
    if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
        $error("param_sequence_detector: CNT_W out of range");
    end

    localparam int                FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] C_FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] r_pattern;
    seqdet_mode_t       r_mode;
    logic [PAT_LEN-1:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic               r_detected;

    logic [PAT_LEN-1:0] w_next_hist;
    logic [FILL_W-1:0]  w_next_fill;
    logic               w_match;
    logic               w_cnt_inc;

    // Shift in the new bit; the fill count tracks how many valid bits hist holds.
    assign w_next_hist = {r_hist[PAT_LEN-2:0], data_in};
    assign w_next_fill = (r_fill == C_FULL) ? C_FULL : r_fill + 1'b1;
    assign w_match     = (w_next_hist == r_pattern) && (w_next_fill == C_FULL);

    // A bit presented together with cfg_load is discarded, so it cannot count.
    assign w_cnt_inc   = en && !cfg_load && w_match;

    // Detector state: configuration, history, fill and the registered flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pattern  <= DEF_PATTERN;
            r_mode     <= DEF_MODE;
            r_hist     <= '0;
            r_fill     <= '0;
            r_detected <= 1'b0;
        end else if (cfg_load) begin
            r_pattern  <= cfg_pattern;
            r_mode     <= seqdet_mode_t'(cfg_mode);
            r_hist     <= '0;
            r_fill     <= '0;
            r_detected <= 1'b0;
        end else if (en) begin
            r_hist     <= w_next_hist;
            r_fill     <= (w_match && r_mode == MODE_NONOVERLAP) ? '0 : w_next_fill;
            r_detected <= w_match;
        end
    end

    seqdet_sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cfg_load),
        .inc   (w_cnt_inc),
        .count (match_count),
        .sat   (count_sat)
    );

    assign detected = r_detected;

endmodule : param_sequence_detector
`default_nettype wire

// File: tb/tb_param_sequence_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_sequence_detector
//  Description : Scoreboard bench for param_sequence_detector. The driver
//                pushes the hand-computed response for every cycle it drives;
//                the monitor pops and compares just after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_sequence_detector;

    typedef struct {
        bit    sel;      // 0: default 4-bit instance, 1: 2-bit pattern / 2-bit counter
        bit    det;
        int    cnt;
        bit    sat;
        string name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       en0 = 1'b0, din0 = 1'b0, ld0 = 1'b0, md0 = 1'b0;
    logic [3:0] pat0 = 4'b0000;
    logic       det0;
    logic [7:0] cnt0;
    logic       sat0;

    logic       en1 = 1'b0, din1 = 1'b0, ld1 = 1'b0, md1 = 1'b0;
    logic [1:0] pat1 = 2'b00;
    logic       det1;
    logic [1:0] cnt1;
    logic       sat1;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    param_sequence_detector dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en0),
        .data_in     (din0),
        .cfg_load    (ld0),
        .cfg_pattern (pat0),
        .cfg_mode    (md0),
        .detected    (det0),
        .match_count (cnt0),
        .count_sat   (sat0)
    );

    param_sequence_detector #(
        .PAT_LEN     (2),
        .CNT_W       (2),
        .DEF_PATTERN (2'b11),
        .DEF_MODE    (seqdet_pkg::MODE_OVERLAP)
    ) dut2 (
        .clk         (clk),
        .reset       (reset),
        .en          (en1),
        .data_in     (din1),
        .cfg_load    (ld1),
        .cfg_pattern (pat1),
        .cfg_mode    (md1),
        .detected    (det1),
        .match_count (cnt1),
        .count_sat   (sat1)
    );

    // ---------------- driver helpers ----------------
    task automatic expect_(input bit sel, input bit xd, input int xc, input bit xs, input string nm);
        exp_t e;
        e.sel = sel; e.det = xd; e.cnt = xc; e.sat = xs; e.name = nm;
        q.push_back(e);
    endtask

    task automatic clear_inputs();
        reset = 1'b1;
        en0 = 1'b0; din0 = 1'b0; ld0 = 1'b0;
        en1 = 1'b0; din1 = 1'b0; ld1 = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        expect_(0, 0, 0, 0, nm);
    endtask

    task automatic bit0(input bit d, input bit xd, input int xc, input string nm);
        @(negedge clk);
        clear_inputs();
        en0 = 1'b1; din0 = d;
        expect_(0, xd, xc, 0, nm);
    endtask

    task automatic idle0(input bit d, input bit xd, input int xc, input string nm);
        @(negedge clk);
        clear_inputs();
        din0 = d;
        expect_(0, xd, xc, 0, nm);
    endtask

    task automatic load0(input logic [3:0] p, input bit m, input bit e, input string nm);
        @(negedge clk);
        clear_inputs();
        ld0 = 1'b1; pat0 = p; md0 = m; en0 = e; din0 = 1'b0;
        expect_(0, 0, 0, 0, nm);
    endtask

    task automatic bit1(input bit d, input bit xd, input int xc, input bit xs, input string nm);
        @(negedge clk);
        clear_inputs();
        en1 = 1'b1; din1 = d;
        expect_(1, xd, xc, xs, nm);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.sel == 1'b0) begin
                    checks++;
                    if (det0 !== e.det) begin failures++; $display("FAIL %s detected got=%0b want=%0b", e.name, det0, e.det); end
                    checks++;
                    if (int'(cnt0) != e.cnt || $isunknown(cnt0)) begin failures++; $display("FAIL %s match_count got=%0d want=%0d", e.name, cnt0, e.cnt); end
                    checks++;
                    if (sat0 !== e.sat) begin failures++; $display("FAIL %s count_sat got=%0b want=%0b", e.name, sat0, e.sat); end
                end else begin
                    checks++;
                    if (det1 !== e.det) begin failures++; $display("FAIL %s detected got=%0b want=%0b", e.name, det1, e.det); end
                    checks++;
                    if (int'(cnt1) != e.cnt || $isunknown(cnt1)) begin failures++; $display("FAIL %s match_count got=%0d want=%0d", e.name, cnt1, e.cnt); end
                    checks++;
                    if (sat1 !== e.sat) begin failures++; $display("FAIL %s count_sat got=%0b want=%0b", e.name, sat1, e.sat); end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit s31[7]  = '{0,1,1,0,1,1,0};
        bit d31[7]  = '{0,0,0,1,0,0,1};
        int c31[7]  = '{0,0,0,1,1,1,2};
        bit s32[11] = '{0,1,1,0,1,1,0,0,1,1,0};
        bit d32[11] = '{0,0,0,1,0,0,0,0,0,0,1};
        int c32[11] = '{0,0,0,1,1,1,1,1,1,1,2};
        bit d33o[6] = '{0,0,0,1,1,1};
        int c33o[6] = '{0,0,0,1,2,3};
        bit d33n[6] = '{0,0,0,1,0,0};
        int c33n[6] = '{0,0,0,1,1,1};
        bit d36[5]  = '{0,1,1,1,1};
        int c36[5]  = '{0,1,2,3,3};
        bit x36[5]  = '{0,0,0,1,1};

        do_reset("reset_a");
        do_reset("reset_b");

        // Default pattern 0110, overlapping
        for (int i = 0; i < 7; i++) bit0(s31[i], d31[i], c31[i], $sformatf("ovl_bit%0d", i + 1));
        idle0(1, 1, 2, "ovl_hold");

        // Non-overlapping 0110
        load0(4'b0110, 0, 0, "load_nonovl");
        for (int i = 0; i < 11; i++) bit0(s32[i], d32[i], c32[i], $sformatf("nonovl_bit%0d", i + 1));

        // All-zero pattern, overlap then non-overlap
        load0(4'b0000, 1, 0, "load_zero_ovl");
        for (int i = 0; i < 6; i++) bit0(0, d33o[i], c33o[i], $sformatf("zero_ovl_bit%0d", i + 1));
        load0(4'b0000, 0, 0, "load_zero_nonovl");
        for (int i = 0; i < 6; i++) bit0(0, d33n[i], c33n[i], $sformatf("zero_nonovl_bit%0d", i + 1));

        // en gaps: bits 0,1, three idle cycles with data_in=1, bits 1,0, then two idle cycles
        do_reset("reset_gap");
        bit0(0, 0, 0, "gap_b1");
        bit0(1, 0, 0, "gap_b2");
        for (int i = 0; i < 3; i++) idle0(1, 0, 0, $sformatf("gap_idle%0d", i));
        bit0(1, 0, 0, "gap_b3");
        bit0(0, 1, 1, "gap_b4");
        idle0(0, 1, 1, "gap_hold1");
        idle0(1, 1, 1, "gap_hold2");

        // Reset mid-sequence discards the partial match
        do_reset("reset_mid_pre");
        bit0(0, 0, 0, "mid_b1");
        bit0(1, 0, 0, "mid_b2");
        bit0(1, 0, 0, "mid_b3");
        do_reset("reset_mid");
        bit0(0, 0, 0, "mid_after");

        // cfg_load with en in the same cycle discards the bit
        bit0(1, 0, 0, "coll_b2");
        bit0(1, 0, 0, "coll_b3");
        load0(4'b0110, 1, 1, "coll_load_en");
        bit0(1, 0, 0, "coll_post1");
        bit0(1, 0, 0, "coll_post2");
        bit0(0, 0, 0, "coll_post3");

        // Reset beats cfg_load: pattern must remain the default 0110
        @(negedge clk);
        clear_inputs();
        reset = 1'b0; ld0 = 1'b1; pat0 = 4'b1111; md0 = 1'b0;
        expect_(0, 0, 0, 0, "rst_over_load");
        bit0(0, 0, 0, "rol_b1");
        bit0(1, 0, 0, "rol_b2");
        bit0(1, 0, 0, "rol_b3");
        bit0(0, 1, 1, "rol_b4");

        // Saturating 2-bit counter, pattern 11 overlap, five ones
        for (int i = 0; i < 5; i++) bit1(1, d36[i], c36[i], x36[i], $sformatf("sat_bit%0d", i + 1));

        @(negedge clk);
        clear_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d entries want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_param_sequence_detector
`default_nettype wire
